// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - debug write-back trace checker against a golden trace ROM
//
// Purpose: consumes the CPU debug_wb_* commit stream and compares every real
// register write (have_inst & ena & reg != 0) against the next golden entry
// read combinationally from an external trace ROM. Ends in PASS (end of trace
// or table full) or FAIL (field mismatch, hang timeout, commit past the end).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   debug_wb_*              retired-instruction write-back stream from the CPU
//   trace_addr / trace_data golden ROM index (registered) / entry
//                           {pc[69:38], reg[37:33], value[32:1], valid[0]}
//   done, pass, fail        terminal status
//   match_cnt               number of matched golden entries
//   err_kind                0 none, 1 pc, 2 reg, 3 value, 4 timeout, 5 overrun
//   err_pc/err_reg/err_got_value  DUT fields captured at failure
//   err_exp_value           golden value captured at failure
module wb_trace_checker #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              debug_wb_have_inst,
    input  logic [31:0]       debug_wb_pc,
    input  logic              debug_wb_ena,
    input  logic [4:0]        debug_wb_reg,
    input  logic [31:0]       debug_wb_value,
    output logic [ADDR_W-1:0] trace_addr,
    input  logic [69:0]       trace_data,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W:0]   match_cnt,
    output logic [2:0]        err_kind,
    output logic [31:0]       err_pc,
    output logic [4:0]        err_reg,
    output logic [31:0]       err_exp_value,
    output logic [31:0]       err_got_value
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PC      = 3'd1;
    localparam logic [2:0] ERR_REG     = 3'd2;
    localparam logic [2:0] ERR_VALUE   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [2:0]          kind_q, kind_d;
    logic [31:0]         epc_q, epc_d;
    logic [4:0]          ereg_q, ereg_d;
    logic [31:0]         eexp_q, eexp_d;
    logic [31:0]         egot_q, egot_d;
    logic                done_q, pass_q, fail_q;

    logic                commit;
    logic [31:0]         g_pc;
    logic [4:0]          g_reg;
    logic [31:0]         g_value;
    logic                g_valid;
    logic [2:0]          mis_kind;

    assign commit  = debug_wb_have_inst & debug_wb_ena & (debug_wb_reg != 5'd0);
    assign g_pc    = trace_data[69:38];
    assign g_reg   = trace_data[37:33];
    assign g_value = trace_data[32:1];
    assign g_valid = trace_data[0];

    // First differing field wins: pc, then reg, then value.
    always_comb begin
        mis_kind = ERR_NONE;
        if (debug_wb_pc != g_pc) begin
            mis_kind = ERR_PC;
        end else if (debug_wb_reg != g_reg) begin
            mis_kind = ERR_REG;
        end else if (debug_wb_value != g_value) begin
            mis_kind = ERR_VALUE;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        kind_d  = kind_q;
        epc_d   = epc_q;
        ereg_d  = ereg_q;
        eexp_d  = eexp_q;
        egot_d  = egot_q;

        case (state_q)
            ST_RUN: begin
                if (!g_valid) begin
                    // A commit past the end of the trace is an error even
                    // though the trace itself has been fully matched.
                    if (commit) begin
                        state_d = ST_FAIL;
                        kind_d  = ERR_OVERRUN;
                        epc_d   = debug_wb_pc;
                        ereg_d  = debug_wb_reg;
                        egot_d  = debug_wb_value;
                        eexp_d  = 32'd0;
                    end else begin
                        state_d = ST_PASS;
                    end
                end else if (commit) begin
                    if (mis_kind != ERR_NONE) begin
                        state_d = ST_FAIL;
                        kind_d  = mis_kind;
                        epc_d   = debug_wb_pc;
                        ereg_d  = debug_wb_reg;
                        egot_d  = debug_wb_value;
                        eexp_d  = g_value;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        tmo_d = '0;
                        // Last ROM slot matched: finish instead of wrapping.
                        if (&addr_q) begin
                            state_d = ST_PASS;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_FAIL;
                    kind_d  = ERR_TIMEOUT;
                    epc_d   = 32'd0;
                    ereg_d  = 5'd0;
                    egot_d  = 32'd0;
                    eexp_d  = 32'd0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_PASS: begin
                if (commit) begin
                    state_d = ST_FAIL;
                    kind_d  = ERR_OVERRUN;
                    epc_d   = debug_wb_pc;
                    ereg_d  = debug_wb_reg;
                    egot_d  = debug_wb_value;
                    eexp_d  = 32'd0;
                end
            end
            default: begin
                // FAIL: everything frozen until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            kind_q  <= ERR_NONE;
            epc_q   <= '0;
            ereg_q  <= '0;
            eexp_q  <= '0;
            egot_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            kind_q  <= kind_d;
            epc_q   <= epc_d;
            ereg_q  <= ereg_d;
            eexp_q  <= eexp_d;
            egot_q  <= egot_d;
            done_q  <= (state_d != ST_RUN);
            pass_q  <= (state_d == ST_PASS);
            fail_q  <= (state_d == ST_FAIL);
        end
    end

    assign trace_addr    = addr_q;
    assign match_cnt     = cnt_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign err_kind      = kind_q;
    assign err_pc        = epc_q;
    assign err_reg       = ereg_q;
    assign err_exp_value = eexp_q;
    assign err_got_value = egot_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb/tb_wb_trace_checker.sv - self-checking bench for wb_trace_checker
module tb_wb_trace_checker;

    localparam int AW    = 4;
    localparam int TMO   = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          have  = 1'b0;
    logic [31:0]   pc_i  = '0;
    logic          ena   = 1'b0;
    logic [4:0]    reg_i = '0;
    logic [31:0]   val_i = '0;
    logic [AW-1:0] trace_addr;
    logic [69:0]   trace_data;
    logic          done, pass, fail;
    logic [AW:0]   match_cnt;
    logic [2:0]    err_kind;
    logic [31:0]   err_pc, err_exp_value, err_got_value;
    logic [4:0]    err_reg;

    logic [69:0]   rom [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    assign trace_data = rom[trace_addr];

    always #5 clk = ~clk;

    wb_trace_checker #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .debug_wb_have_inst (have),
        .debug_wb_pc        (pc_i),
        .debug_wb_ena       (ena),
        .debug_wb_reg       (reg_i),
        .debug_wb_value     (val_i),
        .trace_addr         (trace_addr),
        .trace_data         (trace_data),
        .done               (done),
        .pass               (pass),
        .fail               (fail),
        .match_cnt          (match_cnt),
        .err_kind           (err_kind),
        .err_pc             (err_pc),
        .err_reg            (err_reg),
        .err_exp_value      (err_exp_value),
        .err_got_value      (err_got_value)
    );

    // Reference model: where we are in the golden list, how many matched,
    // how long since the last commit, and the verdict (0 run, 1 pass, 2 fail).
    int          m_st = 0, m_idx = 0, m_matches = 0, m_idle = 0, m_kind = 0;
    logic [31:0] m_epc = '0, m_exp = '0, m_got = '0;
    logic [4:0]  m_ereg = '0;

    task automatic m_fail(input int kind, input bit capture, input logic [31:0] expv);
        m_st   = 2;
        m_kind = kind;
        m_epc  = capture ? pc_i  : 32'd0;
        m_ereg = capture ? reg_i : 5'd0;
        m_got  = capture ? val_i : 32'd0;
        m_exp  = expv;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_idx = 0; m_matches = 0; m_idle = 0; m_kind = 0;
            m_epc = '0; m_exp = '0; m_got = '0; m_ereg = '0;
        end else begin
            logic        is_commit;
            logic [69:0] g;
            is_commit = have && ena && (reg_i != 0);
            g = rom[m_idx];
            if (m_st == 0) begin
                if (is_commit) begin
                    if (!g[0])                m_fail(5, 1, 32'd0);
                    else if (pc_i  != g[69:38]) m_fail(1, 1, g[32:1]);
                    else if (reg_i != g[37:33]) m_fail(2, 1, g[32:1]);
                    else if (val_i != g[32:1])  m_fail(3, 1, g[32:1]);
                    else begin
                        m_matches++;
                        m_idle = 0;
                        if (m_idx == DEPTH - 1) m_st = 1;
                        else m_idx++;
                    end
                end else if (!g[0]) begin
                    m_st = 1;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) m_fail(4, 0, 32'd0);
                end
            end else if (m_st == 1 && is_commit) begin
                m_fail(5, 1, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if (pass !== (m_st == 1) || fail !== (m_st == 2) || done !== (m_st != 0) ||
                trace_addr !== AW'(m_idx) || match_cnt !== (AW+1)'(m_matches) ||
                err_kind !== 3'(m_kind) || err_pc !== m_epc || err_reg !== m_ereg ||
                err_exp_value !== m_exp || err_got_value !== m_got) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got p/f/d=%b%b%b addr=%0d cnt=%0d kind=%0d pc=%h reg=%0d exp=%h got=%h required st=%0d addr=%0d cnt=%0d kind=%0d pc=%h reg=%0d exp=%h got=%h",
                         $time, pass, fail, done, trace_addr, match_cnt, err_kind, err_pc, err_reg,
                         err_exp_value, err_got_value, m_st, m_idx, m_matches, m_kind, m_epc, m_ereg, m_exp, m_got);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic h, input logic [31:0] p, input logic e,
                          input logic [4:0] r, input logic [31:0] v);
        have = h; pc_i = p; ena = e; reg_i = r; val_i = v;
    endtask

    task automatic commit(input logic [31:0] p, input logic [4:0] r, input logic [31:0] v);
        set_in(1'b1, p, 1'b1, r, v);
        step();
    endtask

    task automatic idle();
        set_in(1'b0, $urandom, 1'b0, 5'($urandom), $urandom);
        step();
    endtask

    task automatic do_reset();
        set_in(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_case1();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        rom[0] = {32'h0, 5'd1, 32'd5,  1'b1};
        rom[1] = {32'h4, 5'd2, 32'd7,  1'b1};
        rom[2] = {32'h8, 5'd3, 32'd12, 1'b1};
    endtask

    initial begin
        int          len, p, f;
        logic [69:0] g;
        logic [31:0] cp, cv;
        logic [4:0]  cr;

        load_case1();
        #1 rst_n = 1'b0;
        step();
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // Reset values
        chk("rst_done", done, 0);
        chk("rst_addr", trace_addr, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_kind", err_kind, 0);

        // 1: three back-to-back matches, PASS after the end-of-trace edge
        commit(32'h0, 5'd1, 32'd5);
        commit(32'h4, 5'd2, 32'd7);
        commit(32'h8, 5'd3, 32'd12);
        chk("c1_not_early", pass, 0);
        idle();
        chk("c1_pass", pass, 1);
        chk("c1_cnt", match_cnt, 3);
        chk("c1_kind", err_kind, 0);

        // 5: overrun commit after PASS
        commit(32'hC, 5'd4, 32'd1);
        chk("c5_fail", fail, 1);
        chk("c5_pass", pass, 0);
        chk("c5_kind", err_kind, 5);
        chk("c5_pc", err_pc, 32'hC);
        chk("c5_reg", err_reg, 4);
        chk("c5_exp", err_exp_value, 0);
        chk("c5_got", err_got_value, 1);

        // 2: value mismatch on the second entry
        do_reset();
        commit(32'h0, 5'd1, 32'd5);
        commit(32'h4, 5'd2, 32'd8);
        chk("c2_fail", fail, 1);
        chk("c2_kind", err_kind, 3);
        chk("c2_pc", err_pc, 32'h4);
        chk("c2_reg", err_reg, 2);
        chk("c2_exp", err_exp_value, 7);
        chk("c2_got", err_got_value, 8);
        chk("c2_cnt", match_cnt, 1);
        chk("c2_addr", trace_addr, 1);
        commit(32'h8, 5'd3, 32'd12);
        chk("c2_frozen_cnt", match_cnt, 1);

        // 3: x0 writes, non-writing and idle cycles are ignored
        do_reset();
        commit(32'h0, 5'd1, 32'd5);
        set_in(1'b1, 32'h4, 1'b1, 5'd0, 32'd99); step();
        set_in(1'b1, 32'h4, 1'b0, 5'd2, 32'd99); step();
        commit(32'h4, 5'd2, 32'd7);
        idle();
        commit(32'h8, 5'd3, 32'd12);
        idle();
        chk("c3_pass", pass, 1);
        chk("c3_cnt", match_cnt, 3);

        // 4: hang timeout after exactly TMO idle cycles
        do_reset();
        for (int i = 0; i < TMO - 1; i++) idle();
        chk("c4_not_early", fail, 0);
        idle();
        chk("c4_fail", fail, 1);
        chk("c4_kind", err_kind, 4);
        chk("c4_pc", err_pc, 0);

        // 6: asynchronous reset mid-run, then rerun case 1
        do_reset();
        commit(32'h0, 5'd1, 32'd5);
        commit(32'h4, 5'd2, 32'd7);
        chk("c6_cnt_before", match_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("c6_async_cnt", match_cnt, 0);
        chk("c6_async_addr", trace_addr, 0);
        step();
        rst_n = 1'b1;
        commit(32'h0, 5'd1, 32'd5);
        commit(32'h4, 5'd2, 32'd7);
        commit(32'h8, 5'd3, 32'd12);
        idle();
        chk("c6_rerun_pass", pass, 1);

        // Table full: all slots valid, last match finishes without wrapping
        for (int i = 0; i < DEPTH; i++)
            rom[i] = {$urandom, 5'($urandom_range(1, 31)), $urandom, 1'b1};
        do_reset();
        for (int i = 0; i < DEPTH; i++) commit(rom[i][69:38], rom[i][37:33], rom[i][32:1]);
        chk("full_pass", pass, 1);
        chk("full_cnt", match_cnt, DEPTH);
        chk("full_addr", trace_addr, DEPTH - 1);

        // Random traces and random commit streams, checked every cycle
        for (int r = 0; r < 60; r++) begin
            len = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++)
                rom[i] = (i < len) ? {$urandom, 5'($urandom_range(1, 31)), $urandom, 1'b1} : 70'd0;
            do_reset();
            for (int c = 0; c < 70; c++) begin
                p = $urandom_range(0, 99);
                g = rom[m_idx];
                if (m_st == 0 && g[0] && p < 60) begin
                    commit(g[69:38], g[37:33], g[32:1]);
                end else if (p < 66) begin
                    cp = g[69:38]; cr = g[37:33]; cv = g[32:1];
                    f = $urandom_range(0, 2);
                    if (f == 0) cp = cp ^ (32'd1 << $urandom_range(0, 31));
                    else if (f == 1) cr = (cr == 5'd31 || cr == 5'd0) ? 5'd1 : cr + 5'd1;
                    else cv = cv ^ (32'd1 << $urandom_range(0, 31));
                    commit(cp, cr, cv);
                end else if (p < 74) begin
                    set_in(1'b1, $urandom, 1'b1, 5'd0, $urandom); step();
                end else if (p < 82) begin
                    set_in(1'b1, $urandom, 1'b0, 5'($urandom), $urandom); step();
                end else if (p < 85) begin
                    commit($urandom, 5'($urandom_range(1, 31)), $urandom);
                end else begin
                    idle();
                end
            end
        end

        set_in(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
